// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the AES key-schedule datapath:
//     - ks_state_e   : key-schedule FSM states (IDLE / RUN / DONE)
//     - rcon_byte()  : round-constant byte table, indices 1..10
//     - total_words(): number of 32-bit schedule words, 4*(nr+1)
//     - cfg_legal()  : legal (nk, nr) pairing check used at elaboration
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ks_state_e;

    // Round constant high byte; entries outside 1..10 are never used.
    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic int total_words(input int nr);
        return 4 * (nr + 1);
    endfunction

    function automatic bit cfg_legal(input int nk, input int nr);
        return ((nk == 4) && (nr == 10)) ||
               ((nk == 6) && (nr == 12)) ||
               ((nk == 8) && (nr == 14));
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// -----------------------------------------------------------------------------
// aes_sbox_word
//   Combinational AES S-box applied to each byte of a 32-bit word.
//   Ports:
//     i_word  [31:0]  input word
//     o_word  [31:0]  bytewise S-box substitution of i_word
// -----------------------------------------------------------------------------
module aes_sbox_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    always_comb begin
        o_word = {sub_byte(i_word[31:24]), sub_byte(i_word[23:16]),
                  sub_byte(i_word[15:8]),  sub_byte(i_word[7:0])};
    end

endmodule

// File: rtl/key_schedule_seq.sv
// -----------------------------------------------------------------------------
// key_schedule_seq
//   Sequential AES key expansion. A start pulse captures the cipher key, then
//   one schedule word is produced per clock into the flat round-key vector w.
//   done rises once all (nr+1) round keys are valid and holds until the next
//   accepted start or reset.
//
//   Parameters: nk (4/6/8 key words), nr (must equal nk+6).
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   synchronous active-high reset
//     start  in   expand request, honoured only while busy=0
//     key    in   cipher key, word 0 = key[nk*32-1 -: 32]
//     busy   out  expansion in progress
//     done   out  w complete and stable
//     w      out  schedule, word k at w[32k +: 32], round r at w[128r +: 128]
//   Optional (macro KEY_SCHED_STREAM_EN):
//     word_valid / word_idx / word_out  stream of every schedule word, 0..4*(nr+1)-1
// -----------------------------------------------------------------------------
module key_schedule_seq
    import aes_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [(nk*32)-1:0]                 key,
    output logic                               busy,
    output logic                               done,
    output logic [0:((nr+1)*128)-1]            w
`ifdef KEY_SCHED_STREAM_EN
    ,
    output logic                               word_valid,
    output logic [$clog2(4*(nr+1)+1)-1:0]      word_idx,
    output logic [31:0]                        word_out
`endif
);

    localparam int NW     = total_words(nr);
    localparam int IW     = $clog2(NW + 1);
    localparam bit CFG_OK = cfg_legal(nk, nr);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("key_schedule_seq: illegal (nk, nr) pairing");
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    ks_state_e        r_state;
    ks_state_e        w_state_nxt;
    logic             w_load;
    logic             w_step;

    logic [31:0]      r_word [NW];
    logic [IW-1:0]    r_idx;
    logic [2:0]       r_phase;     // tracks i mod nk without a divider
    logic [3:0]       r_rcon_idx;  // tracks i / nk for the round constant

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_idx == IW'(NW - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Word generation: one shared S-box, fed either RotWord(temp) or temp.
    // ------------------------------------------------------------------
    logic [IW-1:0] w_idx_m1;
    logic [IW-1:0] w_idx_mnk;
    logic [31:0]   w_temp;
    logic [31:0]   w_prev;
    logic [31:0]   w_sbox_in;
    logic [31:0]   w_sbox_out;
    logic [31:0]   w_new;
    logic          w_phase_zero;

    // Clamp the read indices so IDLE (index 0) never addresses outside the array.
    assign w_idx_m1     = (r_idx >= IW'(1))  ? r_idx - IW'(1)  : '0;
    assign w_idx_mnk    = (r_idx >= IW'(nk)) ? r_idx - IW'(nk) : '0;
    assign w_temp       = r_word[w_idx_m1];
    assign w_prev       = r_word[w_idx_mnk];
    assign w_phase_zero = (r_phase == 3'd0);
    assign w_sbox_in    = w_phase_zero ? {w_temp[23:0], w_temp[31:24]} : w_temp;

    aes_sbox_word u_sbox (
        .i_word (w_sbox_in),
        .o_word (w_sbox_out)
    );

    always_comb begin
        w_new = w_prev ^ w_temp;
        if (w_phase_zero) begin
            w_new = w_prev ^ w_sbox_out ^ {rcon_byte(r_rcon_idx), 24'h0};
        end else if ((nk == 8) && (r_phase == 3'd4)) begin
            w_new = w_prev ^ w_sbox_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NW; k++) begin
                r_word[k] <= '0;
            end
            r_idx      <= '0;
            r_phase    <= '0;
            r_rcon_idx <= 4'd1;
        end else if (w_load) begin
            // Only the key words are refreshed; higher words stay stale until written.
            for (int k = 0; k < nk; k++) begin
                r_word[k] <= key[(nk*32)-1-32*k -: 32];
            end
            r_idx      <= IW'(nk);
            r_phase    <= '0;
            r_rcon_idx <= 4'd1;
        end else if (w_step) begin
            r_word[r_idx] <= w_new;
            // RUN leaves after index NW-1, so the counter settles at NW.
            r_idx <= r_idx + IW'(1);
            if (r_phase == 3'(nk - 1)) begin
                r_phase    <= '0;
                r_rcon_idx <= r_rcon_idx + 4'd1;
            end else begin
                r_phase <= r_phase + 3'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NW; k++) begin
            w[32*k +: 32] = r_word[k];
        end
    end

`ifdef KEY_SCHED_STREAM_EN
    // ------------------------------------------------------------------
    // Word stream. It starts the cycle after the load and trails the
    // generator by nk words, reading each word once it is written. It is
    // independent of the FSM, so done is never delayed; the last nk words
    // therefore come out during the first nk cycles of DONE.
    // ------------------------------------------------------------------
    logic          r_stream_on;
    logic [IW-1:0] r_sidx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stream_on <= 1'b0;
            r_sidx      <= '0;
            word_valid  <= 1'b0;
            word_idx    <= '0;
            word_out    <= '0;
        end else if (w_load) begin
            r_stream_on <= 1'b1;
            r_sidx      <= '0;
            word_valid  <= 1'b0;
        end else if (r_stream_on) begin
            word_valid <= 1'b1;
            word_idx   <= r_sidx;
            word_out   <= r_word[r_sidx];
            if (r_sidx == IW'(NW - 1)) begin
                r_stream_on <= 1'b0;
            end else begin
                r_sidx <= r_sidx + IW'(1);
            end
        end else begin
            word_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_key_schedule_seq.sv
// -----------------------------------------------------------------------------
// tb_key_schedule_seq
//   Directed bench for key_schedule_seq with one instance per key length
//   (nk = 4, 6, 8). Expected words come from FIPS-197 worked examples.
// -----------------------------------------------------------------------------
module tb_key_schedule_seq;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset4;
    logic reset68;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic           start4, start6, start8;
    logic [127:0]   key4;
    logic [191:0]   key6;
    logic [255:0]   key8;
    logic           busy4, busy6, busy8;
    logic           done4, done6, done8;
    logic [0:1407]  w4;
    logic [0:1663]  w6;
    logic [0:1919]  w8;

`ifdef KEY_SCHED_STREAM_EN
    logic           word_valid4, word_valid6, word_valid8;
    logic [5:0]     word_idx4, word_idx6, word_idx8;
    logic [31:0]    word_out4, word_out6, word_out8;
`endif

    key_schedule_seq #(.nk(4), .nr(10)) dut4 (
        .clk(clk), .reset(reset4), .start(start4), .key(key4),
        .busy(busy4), .done(done4), .w(w4)
`ifdef KEY_SCHED_STREAM_EN
        , .word_valid(word_valid4), .word_idx(word_idx4), .word_out(word_out4)
`endif
    );

    key_schedule_seq #(.nk(6), .nr(12)) dut6 (
        .clk(clk), .reset(reset68), .start(start6), .key(key6),
        .busy(busy6), .done(done6), .w(w6)
`ifdef KEY_SCHED_STREAM_EN
        , .word_valid(word_valid6), .word_idx(word_idx6), .word_out(word_out6)
`endif
    );

    key_schedule_seq #(.nk(8), .nr(14)) dut8 (
        .clk(clk), .reset(reset68), .start(start8), .key(key8),
        .busy(busy8), .done(done8), .w(w8)
`ifdef KEY_SCHED_STREAM_EN
        , .word_valid(word_valid8), .word_idx(word_idx8), .word_out(word_out8)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] get_word(input int sel, input int idx);
        logic [31:0] v;
        case (sel)
            4:       v = w4[32*idx +: 32];
            6:       v = w6[32*idx +: 32];
            default: v = w8[32*idx +: 32];
        endcase
        return v;
    endfunction

    function automatic logic get_done(input int sel);
        logic v;
        case (sel)
            4:       v = done4;
            6:       v = done6;
            default: v = done8;
        endcase
        return v;
    endfunction

    // Pulse start for one edge on the selected instance and count cycles to done.
    task automatic run_start(input int sel, output int cycles);
        case (sel)
            4:       start4 = 1'b1;
            6:       start6 = 1'b1;
            default: start8 = 1'b1;
        endcase
        tick();
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
        cycles = 0;
        while (!get_done(sel) && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          sel;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vq[$];

`ifdef KEY_SCHED_STREAM_EN
    bit stream_mon = 1'b0;
    int s_next     = 0;

    always @(negedge clk) begin
        if (stream_mon && word_valid4) begin
            check("stream_idx", 128'(word_idx4), 128'(s_next));
            if (s_next == 0)  check("stream_w0",  128'(word_out4), 128'(32'h2b7e1516));
            if (s_next == 4)  check("stream_w4",  128'(word_out4), 128'(32'ha0fafe17));
            if (s_next == 43) check("stream_w43", 128'(word_out4), 128'(32'hb6630ca6));
            s_next++;
        end
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;

        reset4 = 1'b1; reset68 = 1'b1;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        key4 = '0; key6 = '0; key8 = '0;
        repeat (3) tick();
        reset4 = 1'b0; reset68 = 1'b0;

        // Reset state
        check("rst_busy4", 128'(busy4), 128'd0);
        check("rst_done4", 128'(done4), 128'd0);
        check("rst_w4_zero", 128'(w4 == '0), 128'd1);
        check("rst_busy8", 128'(busy8), 128'd0);
        check("rst_done8", 128'(done8), 128'd0);
        check("rst_w8_zero", 128'(w8 == '0), 128'd1);

        // Expansions for the three key lengths
        key4 = KEY_A1;
        run_start(4, cyc);
        check("a1_latency", 128'(cyc), 128'd40);
        check("a1_busy_at_done", 128'(busy4), 128'd0);

        key6 = KEY_A2;
        run_start(6, cyc);
        check("a2_latency", 128'(cyc), 128'd46);
        check("a2_busy_at_done", 128'(busy6), 128'd0);

        key8 = KEY_C3;
        run_start(8, cyc);
        check("c3_latency", 128'(cyc), 128'd52);
        check("c3_busy_at_done", 128'(busy8), 128'd0);

        vq.push_back('{"a1_w0",  4, 0,  32'h2b7e1516});
        vq.push_back('{"a1_w3",  4, 3,  32'h09cf4f3c});
        vq.push_back('{"a1_w4",  4, 4,  32'ha0fafe17});
        vq.push_back('{"a1_w5",  4, 5,  32'h88542cb1});
        vq.push_back('{"a1_w6",  4, 6,  32'h23a33939});
        vq.push_back('{"a1_w7",  4, 7,  32'h2a6c7605});
        vq.push_back('{"a1_w40", 4, 40, 32'hd014f9a8});
        vq.push_back('{"a1_w43", 4, 43, 32'hb6630ca6});
        vq.push_back('{"a2_w0",  6, 0,  32'h8e73b0f7});
        vq.push_back('{"a2_w5",  6, 5,  32'h522c6b7b});
        vq.push_back('{"a2_w6",  6, 6,  32'hfe0c91f7});
        vq.push_back('{"a2_w51", 6, 51, 32'h01002202});
        vq.push_back('{"c3_w8",  8, 8,  32'ha573c29f});
        vq.push_back('{"c3_w11", 8, 11, 32'ha572c09c});
        vq.push_back('{"c3_w12", 8, 12, 32'h1651a8cd});
        vq.push_back('{"c3_w56", 8, 56, 32'h24fc79cc});
        vq.push_back('{"c3_w57", 8, 57, 32'hbf0979e9});
        vq.push_back('{"c3_w58", 8, 58, 32'h371ac23c});
        vq.push_back('{"c3_w59", 8, 59, 32'h6d68de36});

        for (int i = 0; i < vq.size(); i++) begin
            check(vq[i].name, 128'(get_word(vq[i].sel, vq[i].idx)), 128'(vq[i].exp));
        end
        check("c3_round14", w8[1792 +: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // DONE holds w and done while key changes
        key4 = KEY_C1;
        repeat (5) tick();
        check("hold_done", 128'(done4), 128'd1);
        check("hold_w4", 128'(get_word(4, 4)), 128'(32'ha0fafe17));

        // Restart from DONE with a new key; key changes after accept are ignored
        key4   = KEY_C1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        key4   = KEY_A1;
        check("restart_done_low", 128'(done4), 128'd0);
        check("restart_busy_high", 128'(busy4), 128'd1);
        cyc = 0;
        while (!done4 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("c1_latency", 128'(cyc), 128'd40);
        check("c1_round1", w4[128 +: 128], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("c1_round10", w4[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Extra start pulses while busy are ignored
        key4   = KEY_A1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        key4   = KEY_C1;
        cyc = 0;
        while (!done4 && cyc < 200) begin
            start4 = (cyc == 4) || (cyc == 19);
            tick();
            start4 = 1'b0;
            cyc++;
        end
        check("busy_start_latency", 128'(cyc), 128'd40);
        check("busy_start_w4", 128'(get_word(4, 4)), 128'(32'ha0fafe17));
        check("busy_start_w43", 128'(get_word(4, 43)), 128'(32'hb6630ca6));

        // Reset at cycle 17 of a run aborts everything
        key4   = KEY_C1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (16) tick();
        check("mid_run_busy", 128'(busy4), 128'd1);
        reset4 = 1'b1;
        tick();
        reset4 = 1'b0;
        check("abort_busy", 128'(busy4), 128'd0);
        check("abort_done", 128'(done4), 128'd0);
        check("abort_w_zero", 128'(w4 == '0), 128'd1);

        // Fresh start after the abort
`ifdef KEY_SCHED_STREAM_EN
        stream_mon = 1'b1;
`endif
        key4 = KEY_A1;
        run_start(4, cyc);
        check("fresh_latency", 128'(cyc), 128'd40);
        check("fresh_w4", 128'(get_word(4, 4)), 128'(32'ha0fafe17));
        check("fresh_w43", 128'(get_word(4, 43)), 128'(32'hb6630ca6));
        repeat (8) tick();
        check("fresh_done_held", 128'(done4), 128'd1);
`ifdef KEY_SCHED_STREAM_EN
        check("stream_len", 128'(s_next), 128'd44);
        check("stream_idle_valid", 128'(word_valid4), 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
